// File: rtl/jk_pkg.sv
// Shared command encoding and JK next-state helpers for the drive sequencer
// and anything that needs to model the flip-flop it drives.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Returns {j,k} for a command opcode.
  function automatic logic [1:0] op_to_jk(input op_t op);
    logic [1:0] jk;
    case (op)
      OP_HOLD:   jk = 2'b00;
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11:   nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_drive_seq_if.sv
// Command handshake between a command producer and the JK drive sequencer.
interface jk_drive_seq_if #(parameter int CNT_W = 4);
  import jk_pkg::*;

  logic             cmd_valid;
  op_t              cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_ready;

  modport master (output cmd_valid, output cmd_op, output cmd_cnt, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Registered command FIFO with first-word fall-through read data; writes
// while full and reads while empty are dropped internally.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_s;
  logic             pop_s;

  // Extra pointer MSB tells a wrapped (full) pointer pair from an equal (empty) one.
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign push_s  = wr_en && !full;
  assign pop_s   = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/jk_drive_seq.sv
// Replays queued {op, repeat} commands onto a JK flip-flop's j/k inputs and
// checks the flip-flop output against an internal reference model.
module jk_drive_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_drive_seq_if.slave        cmd,
  output logic                 j,
  output logic                 k,
  input  logic                 q_in,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [7:0]           err_cnt
);
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_r;
  logic [CNT_W-1:0] rem_r;
  logic             j_r, k_r, done_r;
  logic             exp_q_r, armed_r, mismatch_r;
  logic [7:0]       err_cnt_r;
  logic             full_s, empty_s, pop_s;
  logic [CNT_W+1:0] head_s;
  op_t              head_op_s;
  logic [CNT_W-1:0] head_cnt_s;

  jk_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CNT_W + 2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd.cmd_valid),
    .wr_data ({cmd.cmd_op, cmd.cmd_cnt}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign head_op_s     = op_t'(head_s[CNT_W+1:CNT_W]);
  assign head_cnt_s    = head_s[CNT_W-1:0];
  assign cmd.cmd_ready = !full_s;
  assign busy          = (state_r == ST_RUN) || !empty_s;
  assign j             = j_r;
  assign k             = k_r;
  assign done          = done_r;
  assign mismatch      = mismatch_r;
  assign err_cnt       = err_cnt_r;

  // Pop whenever the executor is ready for a new command, so commands chain without a bubble.
  always_comb begin
    pop_s = 1'b0;
    if (empty_s) begin
      pop_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pop_s = 1'b1;
    end else if (rem_r == {CNT_W{1'b0}}) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Executor FSM with registered j/k/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rem_r   <= {CNT_W{1'b0}};
      j_r     <= 1'b0;
      k_r     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            {j_r, k_r} <= op_to_jk(head_op_s);
            rem_r      <= head_cnt_s;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rem_r != {CNT_W{1'b0}}) begin
            rem_r <= rem_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            done_r <= 1'b1;
            if (pop_s) begin
              {j_r, k_r} <= op_to_jk(head_op_s);
              rem_r      <= head_cnt_s;
            end else begin
              j_r     <= 1'b0;
              k_r     <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          j_r     <= 1'b0;
          k_r     <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Reference model and checker; the first edge after reset only arms the check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_r    <= 1'b0;
      armed_r    <= 1'b0;
      mismatch_r <= 1'b0;
      err_cnt_r  <= 8'd0;
    end else begin
      exp_q_r <= jk_next(exp_q_r, j_r, k_r);
      armed_r <= 1'b1;
      if (armed_r && (q_in != exp_q_r)) begin
        mismatch_r <= 1'b1;
        if (err_cnt_r != ERR_MAX) err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed bench for jk_drive_seq: stimulus queues expected drive cycles,
// a negedge monitor pops and compares them against j/k/q/done.
module tb_jk_drive_seq;
  import jk_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic j;
    logic k;
    logic q;
    logic last;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       j, k, q_in, busy, done, mismatch;
  logic [7:0] err_cnt;
  logic       ff_q;
  logic       stuck = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  ent_t sb_q[$];
  logic obs_q[$];
  logic model_q = 1'b0;
  ent_t prev_e;
  logic have_prev = 1'b0;

  jk_drive_seq_if #(.CNT_W(CNT_W)) cmd_if ();

  jk_drive_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .j        (j),
    .k        (k),
    .q_in     (q_in),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // The real flip-flop the sequencer drives, optionally with its output stuck at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= 1'b0;
    else     ff_q <= jk_next(ff_q, j, k);
  end
  assign q_in = stuck ? 1'b0 : ff_q;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Independent hand model of the flip-flop for expected q values.
  function automatic logic hand_q(input logic q, input logic [1:0] jk);
    case (jk)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic push(input op_t op, input int cnt, output int stalls);
    logic       r;
    logic       acc;
    logic [1:0] jk;
    ent_t       e;
    stalls = 0;
    acc = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cnt   = cnt[CNT_W-1:0];
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      r = cmd_if.cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1'b1;
        break;
      end
      stalls++;
    end
    cmd_if.cmd_valid = 1'b0;
    if (!acc) begin
      chk("push_timeout", 0, 1);
    end else begin
      jk = (op == OP_SET) ? 2'b10 : (op == OP_RESET) ? 2'b01 : (op == OP_TOGGLE) ? 2'b11 : 2'b00;
      for (int i = 0; i <= cnt; i++) begin
        model_q = hand_q(model_q, jk);
        e.j = jk[1];
        e.k = jk[0];
        e.q = stuck ? 1'b0 : model_q;
        e.last = (i == cnt);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk("idle_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stuck = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    sb_q.delete();
    obs_q.delete();
    model_q = 1'b0;
    done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected entry per non-HOLD drive cycle.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        chk("done", int'(done), (have_prev && prev_e.last) ? 1 : 0);
        if (done) done_seen++;
        if (have_prev) begin
          chk("q", int'(q_in), int'(prev_e.q));
          obs_q.push_back(q_in);
        end
        if (j || k) begin
          if (sb_q.size() == 0) begin
            chk("jk_unexpected", int'({j, k}), 0);
            have_prev = 1'b0;
          end else begin
            e = sb_q.pop_front();
            chk("jk", int'({j, k}), int'({e.j, e.k}));
            prev_e = e;
            have_prev = 1'b1;
          end
        end else begin
          have_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   st;
    logic exp7 [7];
    logic exp3 [3];
    exp7 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp3 = '{1'b1, 1'b1, 1'b0};
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_HOLD;
    cmd_if.cmd_cnt   = '0;

    // Reset values and quiet idle after release.
    do_reset();
    chk("rst_ready", int'(cmd_if.cmd_ready), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_jk", int'({j, k}), 0);
      chk("idle_q", int'(q_in), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_mismatch", int'(mismatch), 0);
    end

    // SET cnt=2 then TOGGLE cnt=3 back-to-back.
    obs_q.delete();
    done_seen = 0;
    push(OP_SET, 2, st);
    push(OP_TOGGLE, 3, st);
    wait_idle(60);
    chk("seq_len", obs_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < obs_q.size()) chk("seq_q", int'(obs_q[i]), int'(exp7[i]));
    end
    chk("seq_done_cnt", done_seen, 2);
    chk("seq_err", int'(err_cnt), 0);

    // Fill the FIFO behind a long command; the 5th push must stall.
    push(OP_TOGGLE, 9, st);
    push(OP_SET, 0, st);
    push(OP_RESET, 1, st);
    push(OP_TOGGLE, 2, st);
    push(OP_SET, 1, st);
    chk("full_ready", int'(cmd_if.cmd_ready), 0);
    push(OP_RESET, 0, st);
    chk("fifth_stalled", (st > 0) ? 1 : 0, 1);
    wait_idle(100);
    chk("fill_drained", sb_q.size(), 0);
    chk("fill_err", int'(err_cnt), 0);
    chk("fill_mismatch", int'(mismatch), 0);

    // Stuck-at-0 flip-flop output with SET cnt=0.
    do_reset();
    stuck = 1'b1;
    push(OP_SET, 0, st);
    @(posedge clk); #1;
    chk("stuck_j", int'(j), 1);
    chk("stuck_mm_e1", int'(mismatch), 0);
    @(posedge clk); #1;
    chk("stuck_mm_e2", int'(mismatch), 0);
    @(posedge clk); #1;
    chk("stuck_mm_e3", int'(mismatch), 1);
    chk("stuck_err1", int'(err_cnt), 1);
    repeat (300) @(posedge clk);
    #1;
    chk("stuck_sat", int'(err_cnt), 255);
    chk("stuck_sticky", int'(mismatch), 1);

    // Reset asserted in the 2nd cycle of TOGGLE cnt=7 with 2 commands queued.
    do_reset();
    push(OP_TOGGLE, 7, st);
    push(OP_SET, 1, st);
    push(OP_RESET, 1, st);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_jk", int'({j, k}), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(cmd_if.cmd_ready), 1);
    chk("mid_rst_err", int'(err_cnt), 0);
    sb_q.delete();
    model_q = 1'b0;
    done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done_cnt", done_seen, 0);
    chk("post_rst_mismatch", int'(mismatch), 0);

    // RESET cnt=0 right after SET.
    obs_q.delete();
    push(OP_SET, 1, st);
    push(OP_RESET, 0, st);
    wait_idle(40);
    chk("sr_len", obs_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < obs_q.size()) chk("sr_q", int'(obs_q[i]), int'(exp3[i]));
    end
    chk("sr_mismatch", int'(mismatch), 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
